// File: rtl/jtframe_mbox_pkg.sv
// ============================================================================
// jtframe_mbox_pkg
// Shared constants, width helper and status-byte layout for the sound mailbox.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jtframe_mbox_pkg;

  // Value shown on the FIFO head when the FIFO is empty; slice to the data width.
  localparam logic [63:0] EMPTY_VAL = '1;

  // Pointer width: $clog2(depth), but never below one bit.
  function automatic int mbox_aw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Byte returned to the sound CPU by game-level status port decoders.
  typedef struct packed {
    logic [1:0] level;
    logic [3:0] rsvd;
    logic       main_rdy;
    logic       snd_flag;
  } mbox_status_t;

  function automatic mbox_status_t mbox_status(
    input logic [1:0] level,
    input logic       main_rdy,
    input logic       snd_flag
  );
    mbox_status_t s;
    s.level    = level;
    s.rsvd     = 4'b0;
    s.main_rdy = main_rdy;
    s.snd_flag = snd_flag;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtframe_mbox_fifo.sv
// ============================================================================
// jtframe_mbox_fifo
// Show-ahead command FIFO with push/pop/flush, occupancy level, full and empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtframe_mbox_fifo
  import jtframe_mbox_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = mbox_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH-1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  // Explicit wrap so DEPTH=1 keeps its pointers pinned at zero.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? EMPTY_VAL[DW-1:0] : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/jtframe_snd_mailbox.sv
// ============================================================================
// jtframe_snd_mailbox
// Main<->sound CPU mailbox: command FIFO, reply latch with strobe, gated NMI.
// Optional overrun tracking is built when JTFRAME_MBOX_OVERRUN_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtframe_snd_mailbox
  import jtframe_mbox_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = mbox_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          flush,
  input  logic [DW-1:0] main_din,
  input  logic          main_wr,
  output logic          main_full,
  output logic [DW-1:0] main_dout,
  output logic          main_rdy,
  input  logic          main_rd,
  output logic          main_stb,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  output logic          snd_flag,
  output logic [AW:0]   snd_level,
  input  logic          snd_wr,
  input  logic [DW-1:0] snd_din,
  input  logic          nmi_set,
  input  logic          nmi_clr,
  output logic          nmi_n,
  output logic          overrun,
  output logic [7:0]    drop_cnt
);

  logic fifo_full, fifo_empty;

  jtframe_mbox_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (main_wr),
    .pop   (snd_rd),
    .din   (main_din),
    .dout  (snd_dout),
    .level (snd_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign main_full = fifo_full;
  assign snd_flag  = !fifo_empty;

  // Reply latch
  logic [DW-1:0] main_dout_q, main_dout_d;
  logic          main_rdy_q, main_rdy_d;
  logic          main_stb_q, main_stb_d;

  always_comb begin
    main_dout_d = main_dout_q;
    main_rdy_d  = main_rdy_q;
    main_stb_d  = 1'b0;
    if (main_rd) main_rdy_d = 1'b0;
    // A fresh reply overrides a same-cycle acknowledge.
    if (snd_wr) begin
      main_dout_d = snd_din;
      main_rdy_d  = 1'b1;
      main_stb_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_dout_q <= '0;
      main_rdy_q  <= 1'b0;
      main_stb_q  <= 1'b0;
    end else begin
      main_dout_q <= main_dout_d;
      main_rdy_q  <= main_rdy_d;
      main_stb_q  <= main_stb_d;
    end
  end

  assign main_dout = main_dout_q;
  assign main_rdy  = main_rdy_q;
  assign main_stb  = main_stb_q;

  // NMI enable and level-sensitive, cen-paced NMI output
  logic nmi_en_q, nmi_en_d;
  logic nmi_n_q, nmi_n_d;

  always_comb begin
    nmi_en_d = nmi_en_q;
    if (nmi_set) nmi_en_d = 1'b1;
    if (nmi_clr) nmi_en_d = 1'b0;
    nmi_n_d = cen ? !(nmi_en_q && snd_flag) : nmi_n_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_en_q <= 1'b0;
      nmi_n_q  <= 1'b1;
    end else begin
      nmi_en_q <= nmi_en_d;
      nmi_n_q  <= nmi_n_d;
    end
  end

  assign nmi_n = nmi_n_q;

`ifdef JTFRAME_MBOX_OVERRUN_EN
  logic       overrun_q, overrun_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       drop;

  // Matches the FIFO acceptance rule: a same-cycle pop makes room.
  assign drop = main_wr && fifo_full && !(snd_rd && !fifo_empty);

  always_comb begin
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      overrun_d  = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overrun_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overrun  = overrun_q;
  assign drop_cnt = drop_cnt_q;
`else
  assign overrun  = 1'b0;
  assign drop_cnt = 8'h00;
`endif

endmodule

`default_nettype wire
